// File: rtl/hbridge_guard.sv
//==============================================================================
// Module      : hbridge_guard
// Description : Per-bridge shoot-through and over-drive protection. Each
//               H-bridge request pair passes through its own FSM that
//               inserts a fixed all-off dead time on every turn-on,
//               reversal or release. It also latches a bridge off when one
//               continuous drive period runs past the on-time limit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hbridge_guard #(
    parameter int NUM_BRIDGES   = 7,
    parameter int DEAD_CYCLES   = 8,
    parameter int MAX_ON_CYCLES = 50000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable_sn,
    input  logic [2*NUM_BRIDGES-1:0] bridge_req,
    input  logic                     clear_status,
    output logic [2*NUM_BRIDGES-1:0] bridge_out,
    output logic [NUM_BRIDGES-1:0]   fault,
    output logic [NUM_BRIDGES-1:0]   illegal_seen,
    output logic                     busy
);

    localparam int              c_DW        = $clog2(DEAD_CYCLES + 1);
    localparam logic [c_DW-1:0] c_DEAD_LOAD = c_DW'(DEAD_CYCLES - 1);
    localparam logic [15:0]     c_ON_LIMIT  = 16'(MAX_ON_CYCLES - 1);
    localparam bit              c_LIMIT_EN  = (MAX_ON_CYCLES != 0);

    localparam logic [2:0] c_ST_DEAD  = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_FWD   = 3'd2;
    localparam logic [2:0] c_ST_REV   = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    // Per-bridge "will be driving after this edge" flags, OR-ed into busy.
    logic [NUM_BRIDGES-1:0] w_next_on;
    logic                   r_busy;

    for (genvar gi = 0; gi < NUM_BRIDGES; gi++) begin : g_bridge
        logic [2:0]      r_state;
        logic [2:0]      w_state_nxt;
        logic [c_DW-1:0] r_dead_cnt;
        logic [c_DW-1:0] w_dead_cnt_nxt;
        logic [15:0]     r_on_cnt;
        logic [15:0]     w_on_cnt_nxt;
        logic [1:0]      r_out;
        logic            r_fault;
        logic            r_illegal;
        logic [1:0]      w_req;
        logic [1:0]      w_dir;

        assign w_req = bridge_req[2*gi +: 2];
        // Direction the bridge currently drives; only meaningful in ON states.
        assign w_dir = (r_state == c_ST_FWD) ? 2'b01 : 2'b10;

        // Next-state logic; request 11 falls through as "not a drive request".
        always_comb begin
            w_state_nxt    = r_state;
            w_dead_cnt_nxt = r_dead_cnt;
            w_on_cnt_nxt   = r_on_cnt;
            if (enable_sn) begin
                w_state_nxt    = c_ST_DEAD;
                w_dead_cnt_nxt = c_DEAD_LOAD;
            end else begin
                case (r_state)
                    c_ST_DEAD, c_ST_IDLE: begin
                        if (r_state == c_ST_DEAD && r_dead_cnt != '0) begin
                            w_dead_cnt_nxt = r_dead_cnt - c_DW'(1);
                        end else begin
                            case (w_req)
                                2'b01: begin
                                    w_state_nxt  = c_ST_FWD;
                                    w_on_cnt_nxt = '0;
                                end
                                2'b10: begin
                                    w_state_nxt  = c_ST_REV;
                                    w_on_cnt_nxt = '0;
                                end
                                default: w_state_nxt = c_ST_IDLE;
                            endcase
                        end
                    end
                    c_ST_FWD, c_ST_REV: begin
                        if (w_req != w_dir) begin
                            w_state_nxt    = c_ST_DEAD;
                            w_dead_cnt_nxt = c_DEAD_LOAD;
                        end else if (c_LIMIT_EN && r_on_cnt == c_ON_LIMIT) begin
                            w_state_nxt = c_ST_FAULT;
                        end else if (r_on_cnt != 16'hFFFF) begin
                            w_on_cnt_nxt = r_on_cnt + 16'd1;
                        end
                    end
                    c_ST_FAULT: begin
                        // Stay latched until the requester lets go of the drive.
                        if (w_req == 2'b00 || w_req == 2'b11) begin
                            w_state_nxt    = c_ST_DEAD;
                            w_dead_cnt_nxt = c_DEAD_LOAD;
                        end
                    end
                    default: begin
                        w_state_nxt    = c_ST_DEAD;
                        w_dead_cnt_nxt = c_DEAD_LOAD;
                    end
                endcase
            end
        end

        assign w_next_on[gi] = (w_state_nxt == c_ST_FWD) || (w_state_nxt == c_ST_REV);

        // State, counters and outputs decoded from the next state so they
        // change on the same edge as the state itself.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state    <= c_ST_DEAD;
                r_dead_cnt <= c_DEAD_LOAD;
                r_on_cnt   <= '0;
                r_out      <= 2'b00;
                r_fault    <= 1'b0;
                r_illegal  <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_dead_cnt <= w_dead_cnt_nxt;
                r_on_cnt   <= w_on_cnt_nxt;
                r_out      <= (w_state_nxt == c_ST_FWD) ? 2'b01 :
                              (w_state_nxt == c_ST_REV) ? 2'b10 : 2'b00;
                r_fault    <= (w_state_nxt == c_ST_FAULT);
                // A new illegal request beats a simultaneous clear.
                if (w_req == 2'b11) begin
                    r_illegal <= 1'b1;
                end else if (clear_status) begin
                    r_illegal <= 1'b0;
                end
            end
        end

        assign bridge_out[2*gi +: 2] = r_out;
        assign fault[gi]             = r_fault;
        assign illegal_seen[gi]      = r_illegal;
    end

    // Aggregate activity flag, registered alongside the bridge states.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_next_on;
        end
    end

    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hbridge_guard.sv
//==============================================================================
// Module      : tb_hbridge_guard
// Description : Self-checking bench for hbridge_guard (7 bridges, dead time
//               8, on-time limit 20). A vector table drives the DUT and a
//               scoreboard queue holds the expected outputs until their
//               cycle. Hand-written sequences cover the asynchronous reset.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hbridge_guard;

    localparam int c_NB   = 7;
    localparam int c_DEAD = 8;
    localparam int c_MAX  = 20;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable_sn;
    logic              clear_status;
    logic [2*c_NB-1:0] bridge_req;
    logic [2*c_NB-1:0] bridge_out;
    logic [c_NB-1:0]   fault;
    logic [c_NB-1:0]   illegal_seen;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vec_id   = 0;

    typedef struct {
        logic        en_sn;
        logic [13:0] req;
        logic        clr;
        int          n;
        logic [13:0] out;
        logic [6:0]  flt;
        logic [6:0]  ill;
        logic        bsy;
    } vec_t;

    typedef struct {
        int          at;
        int          id;
        logic [13:0] out;
        logic [6:0]  flt;
        logic [6:0]  ill;
        logic        bsy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    hbridge_guard #(
        .NUM_BRIDGES  (c_NB),
        .DEAD_CYCLES  (c_DEAD),
        .MAX_ON_CYCLES(c_MAX)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_sn   (enable_sn),
        .bridge_req  (bridge_req),
        .clear_status(clear_status),
        .bridge_out  (bridge_out),
        .fault       (fault),
        .illegal_seen(illegal_seen),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Count active edges; expectations are keyed to this number.
    always @(posedge clock) cyc <= cyc + 1;

    // Build one vector: inputs held for n edges, then outputs compared.
    function automatic vec_t mk(input logic en, input logic [13:0] req, input logic clr,
                                input int n, input logic [13:0] out, input logic [6:0] flt,
                                input logic [6:0] ill, input logic bsy);
        vec_t v;
        v.en_sn = en; v.req = req; v.clr = clr; v.n = n;
        v.out = out; v.flt = flt; v.ill = ill; v.bsy = bsy;
        return v;
    endfunction

    // Drive a vector (called on a falling edge) and queue its expectation.
    task automatic apply(input vec_t v);
        exp_t e;
        enable_sn    = v.en_sn;
        bridge_req   = v.req;
        clear_status = v.clr;
        e.at  = cyc + v.n;
        e.id  = vec_id;
        e.out = v.out;
        e.flt = v.flt;
        e.ill = v.ill;
        e.bsy = v.bsy;
        exp_q.push_back(e);
        vec_id++;
        repeat (v.n) @(negedge clock);
    endtask

    task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // Scoreboard: compare queued expectations when their cycle arrives.
    always @(negedge clock) begin
        while (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
            n_checks++;
            if (exp_q[0].at != cyc ||
                {bridge_out, fault, illegal_seen, busy} !==
                {exp_q[0].out, exp_q[0].flt, exp_q[0].ill, exp_q[0].bsy}) begin
                n_errors++;
                $display("FAIL vec%0d cycle %0d: got out=%h fault=%h ill=%h busy=%b, want out=%h fault=%h ill=%h busy=%b",
                         exp_q[0].id, cyc, bridge_out, fault, illegal_seen, busy,
                         exp_q[0].out, exp_q[0].flt, exp_q[0].ill, exp_q[0].bsy);
            end
            void'(exp_q.pop_front());
        end
    end

    // A bridge must never present both legs driven.
    always @(negedge clock) begin
        n_checks++;
        for (int i = 0; i < c_NB; i++) begin
            if (bridge_out[2*i +: 2] == 2'b11) begin
                n_errors++;
                $display("FAIL no_11 bridge %0d cycle %0d: got 11, want 00/01/10", i, cyc);
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        enable_sn    = 1'b0;
        clear_status = 1'b0;
        bridge_req   = 14'h1555;

        // Reset release with every bridge requesting forward.
        for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 14'h1555, 0, 1, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h1555, 0, 1, 14'h1555, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0000, 0, 1, 14'h0000, 0, 0, 0));
        // Bridge 0: forward after dead time, then reversal through dead time.
        for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 14'h0001, 0, 1, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0001, 0, 1, 14'h0001, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0001, 0, 3, 14'h0001, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0002, 0, 1, 14'h0000, 0, 0, 0));
        for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 14'h0002, 0, 1, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0002, 0, 1, 14'h0002, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0000, 0, 1, 14'h0000, 0, 0, 0));
        // Bridge 3 held reverse from IDLE: 20 driven cycles, then fault.
        vecs.push_back(mk(0, 14'h0080, 0, 1,  14'h0080, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0080, 0, 18, 14'h0080, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0080, 0, 1,  14'h0080, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0080, 0, 1,  14'h0000, 7'h08, 0, 0));
        vecs.push_back(mk(0, 14'h0080, 0, 3,  14'h0000, 7'h08, 0, 0));
        vecs.push_back(mk(0, 14'h0000, 0, 1,  14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0080, 0, 7,  14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0080, 0, 1,  14'h0080, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0000, 0, 1,  14'h0000, 0, 0, 0));
        // Bridge 6 illegal request, sticky flag, clear, set-beats-clear.
        vecs.push_back(mk(0, 14'h3000, 0, 1, 14'h0000, 0, 7'h40, 0));
        vecs.push_back(mk(0, 14'h0000, 0, 1, 14'h0000, 0, 7'h40, 0));
        vecs.push_back(mk(0, 14'h0000, 1, 1, 14'h0000, 0, 7'h00, 0));
        vecs.push_back(mk(0, 14'h3000, 1, 1, 14'h0000, 0, 7'h40, 0));
        vecs.push_back(mk(0, 14'h0000, 0, 1, 14'h0000, 0, 7'h40, 0));
        vecs.push_back(mk(0, 14'h0000, 1, 1, 14'h0000, 0, 7'h00, 0));
        // Four bridges driving, enable_sn pulsed high for three cycles.
        vecs.push_back(mk(0, 14'h0000, 0, 2, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0099, 0, 1, 14'h0099, 0, 0, 1));
        vecs.push_back(mk(0, 14'h0099, 0, 2, 14'h0099, 0, 0, 1));
        vecs.push_back(mk(1, 14'h0099, 0, 1, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 14'h0099, 0, 2, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0099, 0, 7, 14'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 14'h0099, 0, 1, 14'h0099, 0, 0, 1));
        // Illegal on idle bridge 6 while others drive (cleared by reset below).
        vecs.push_back(mk(0, 14'h3099, 0, 1, 14'h0099, 0, 7'h40, 1));
        vecs.push_back(mk(0, 14'h0099, 0, 1, 14'h0099, 0, 7'h40, 1));

        @(negedge clock);
        check_now("reset_out",   32'(bridge_out),   32'h0);
        check_now("reset_fault", 32'(fault),        32'h0);
        check_now("reset_ill",   32'(illegal_seen), 32'h0);
        check_now("reset_busy",  32'(busy),         32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[k]) apply(vecs[k]);

        // Asynchronous reset mid-drive: outputs clear without a clock edge.
        #2 reset_n = 1'b0;
        #1;
        check_now("arst_drive_out",  32'(bridge_out),   32'h0);
        check_now("arst_drive_busy", 32'(busy),         32'h0);
        check_now("arst_drive_ill",  32'(illegal_seen), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) apply(mk(0, 14'h0099, 0, 1, 14'h0000, 0, 0, 0));
        apply(mk(0, 14'h0099, 0, 1, 14'h0099, 0, 0, 1));
        apply(mk(0, 14'h0000, 0, 1, 14'h0000, 0, 0, 0));
        apply(mk(0, 14'h0099, 0, 3, 14'h0000, 0, 0, 0));

        // Asynchronous reset mid-DEAD: full dead time restarts afterwards.
        #2 reset_n = 1'b0;
        #1;
        check_now("arst_dead_out", 32'(bridge_out), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) apply(mk(0, 14'h0099, 0, 1, 14'h0000, 0, 0, 0));
        apply(mk(0, 14'h0099, 0, 1, 14'h0099, 0, 0, 1));

        @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
